// File: rtl/banked_dpsram.sv
// banked_dpsram: dual-port (a/b) memory built from BANKS independent
// single-port banks. The bank is selected by the low address bits. When both
// ports hit the same bank in the same cycle, a 1-bit round-robin priority
// register picks the winner.
// Read latency is 1 cycle by default. Defining BANKED_DPSRAM_OREG_EN adds an
// output register on rdata/rvalid, which makes the latency 2 cycles.
// Memory contents are never reset.
module banked_dpsram #(
    parameter int W     = 32,
    parameter int N     = 1024,
    parameter int BANKS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic                 a_wen,
    input  logic [$clog2(N)-1:0] a_addr,
    input  logic [W-1:0]         a_wdata,
    output logic                 a_ready,
    output logic                 a_rvalid,
    output logic [W-1:0]         a_rdata,
    input  logic                 b_valid,
    input  logic                 b_wen,
    input  logic [$clog2(N)-1:0] b_addr,
    input  logic [W-1:0]         b_wdata,
    output logic                 b_ready,
    output logic                 b_rvalid,
    output logic [W-1:0]         b_rdata
);
    localparam int AW   = $clog2(N);
    localparam int BB   = $clog2(BANKS);          // bank-select bits (0 when BANKS = 1)
    localparam int BW   = (BB > 0) ? BB : 1;      // storage width for a bank index
    localparam int RW   = AW - BB;                // row address bits
    localparam int ROWS = N / BANKS;

    // Both ports are folded into 2-entry arrays (0 = a, 1 = b) so the
    // per-port logic is written once.
    logic [1:0]    valid;
    logic [1:0]    wen;
    logic [1:0]    ready;
    logic [1:0]    acc;
    logic [AW-1:0] addr  [2];
    logic [W-1:0]  wdata [2];
    logic [BW-1:0] bank  [2];
    logic [RW-1:0] row   [2];
    logic [1:0]    rvalid_o;
    logic [W-1:0]  rdata_o [2];

    logic          prio_reg;                      // 0 = a wins a conflict, 1 = b wins
    logic          conflict;
    logic [W-1:0]  bank_rdata [BANKS];

    assign valid    = {b_valid, a_valid};
    assign wen      = {b_wen, a_wen};
    assign addr[0]  = a_addr;
    assign addr[1]  = b_addr;
    assign wdata[0] = a_wdata;
    assign wdata[1] = b_wdata;

    assign a_ready  = ready[0];
    assign b_ready  = ready[1];
    assign a_rvalid = rvalid_o[0];
    assign b_rvalid = rvalid_o[1];
    assign a_rdata  = rdata_o[0];
    assign b_rdata  = rdata_o[1];

    // Address split. Masking (instead of slicing) keeps BANKS = 1 legal:
    // every request then maps to bank 0.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_split
            assign bank[gi] = BW'(addr[gi] & AW'(BANKS - 1));
            assign row[gi]  = RW'(addr[gi] >> BB);
        end
    endgenerate

    // Arbitration. Ready depends only on the valids, the bank indices,
    // the priority register and reset, never on the read-return path.
    always_comb begin
        conflict = valid[0] & valid[1] & (bank[0] == bank[1]);
        ready[0] = ~rst & (~conflict | ~prio_reg);
        ready[1] = ~rst & (~conflict | prio_reg);
        acc      = valid & ready;
    end

    // Priority register: on a conflict, priority passes to the port that lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (conflict) begin
            prio_reg <= ~prio_reg;
        end
    end

    // Banks. Arbitration guarantees at most one accepted access per bank,
    // so each bank is a plain single-port RAM with a registered read.
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [W-1:0]  mem [ROWS];
            logic [W-1:0]  rd_reg;
            logic          sel_a;
            logic          sel_b;
            logic          en;
            logic          we;
            logic [RW-1:0] bank_row;
            logic [W-1:0]  bank_wd;

            // Steer the port that owns this bank in this cycle.
            always_comb begin
                sel_a    = acc[0] & (bank[0] == BW'(gi));
                sel_b    = acc[1] & (bank[1] == BW'(gi));
                en       = sel_a | sel_b;
                we       = sel_a ? wen[0]   : wen[1];
                bank_row = sel_a ? row[0]   : row[1];
                bank_wd  = sel_a ? wdata[0] : wdata[1];
            end

            // The write commits at the end of the acceptance cycle. The read
            // register updates only on reads, so it holds between reads.
            always_ff @(posedge clk) begin
                if (en & we) begin
                    mem[bank_row] <= bank_wd;
                end
                if (en & ~we) begin
                    rd_reg <= mem[bank_row];
                end
            end

            assign bank_rdata[gi] = rd_reg;
        end
    endgenerate

    // Read return per port: remember which bank served the read, then
    // present that bank's read register.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic          pend_reg;
            logic [BW-1:0] rbank_reg;
            logic          rvalid_int;
            logic [W-1:0]  rdata_int;

            // Track an accepted read for one cycle and latch its bank index.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_reg  <= 1'b0;
                    rbank_reg <= '0;
                end else begin
                    pend_reg <= acc[gi] & ~wen[gi];
                    if (acc[gi]) begin
                        rbank_reg <= bank[gi];
                    end
                end
            end

            // A read that is in flight while rst is high is dropped.
            // Masking here stops it from surfacing in the reset cycle itself.
            assign rvalid_int = pend_reg & ~rst;
            assign rdata_int  = bank_rdata[rbank_reg];

`ifdef BANKED_DPSRAM_OREG_EN
            logic         rvalid_reg;
            logic [W-1:0] rdata_reg;

            // Extra output stage. rdata holds its last value between returns.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rvalid_int;
                    if (rvalid_int) begin
                        rdata_reg <= rdata_int;
                    end
                end
            end

            assign rvalid_o[gi] = rvalid_reg;
            assign rdata_o[gi]  = rdata_reg;
`else
            logic [W-1:0] hold_reg;

            // Keep the last returned word so rdata is stable while rvalid = 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (rvalid_int) begin
                    hold_reg <= rdata_int;
                end
            end

            assign rvalid_o[gi] = rvalid_int;
            assign rdata_o[gi]  = rvalid_int ? rdata_int : hold_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_banked_dpsram.sv
// Directed self-checking bench for banked_dpsram. It drives a 4-bank
// instance and a 1-bank instance. The expected read latency follows
// BANKED_DPSRAM_OREG_EN.
module tb_banked_dpsram;
`ifdef BANKED_DPSRAM_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk;
    logic        rst;

    // 4-bank instance
    logic        a_valid, a_wen, a_ready, a_rvalid;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_valid, b_wen, b_ready, b_rvalid;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    // 1-bank instance
    logic        sa_valid, sa_wen, sa_ready, sa_rvalid;
    logic [3:0]  sa_addr;
    logic [31:0] sa_wdata, sa_rdata;
    logic        sb_valid, sb_wen, sb_ready, sb_rvalid;
    logic [3:0]  sb_addr;
    logic [31:0] sb_wdata, sb_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int a_cnt;
    int b_cnt;

    banked_dpsram #(.W(32), .N(1024), .BANKS(4)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    banked_dpsram #(.W(32), .N(16), .BANKS(1)) u_one (
        .clk(clk), .rst(rst),
        .a_valid(sa_valid), .a_wen(sa_wen), .a_addr(sa_addr), .a_wdata(sa_wdata),
        .a_ready(sa_ready), .a_rvalid(sa_rvalid), .a_rdata(sa_rdata),
        .b_valid(sb_valid), .b_wen(sb_wen), .b_addr(sb_addr), .b_wdata(sb_wdata),
        .b_ready(sb_ready), .b_rvalid(sb_rvalid), .b_rdata(sb_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid = 0; a_wen = 0; a_addr = '0; a_wdata = '0;
        b_valid = 0; b_wen = 0; b_addr = '0; b_wdata = '0;
        sa_valid = 0; sa_wen = 0; sa_addr = '0; sa_wdata = '0;
        sb_valid = 0; sb_wen = 0; sb_addr = '0; sb_wdata = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step(); step();

        // Reset: ready stays low even when a request is presented.
        a_valid = 1; a_wen = 1; a_addr = 10'd6; a_wdata = 32'h0BAD0BAD;
        b_valid = 1; b_wen = 0; b_addr = 10'd7;
        #1;
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        step();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_one_b_rdata", sb_rdata, 32'd0);

        // a writes 0xDEADBEEF at address 5; b reads address 5 in the next cycle.
        step();
        a_valid = 1; a_wen = 1; a_addr = 10'd5; a_wdata = 32'hDEADBEEF;
        #1;
        chk("wr5_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        idle();
        b_valid = 1; b_wen = 0; b_addr = 10'd5;
        #1;
        chk("rd5_b_ready", {31'd0, b_ready}, 32'd1);
        step();
        idle();
        lat = 1;
        while (b_rvalid !== 1'b1 && lat < 6) begin
            step();
            lat++;
        end
        chk("rd5_latency", lat, L);
        chk("rd5_b_rdata", b_rdata, 32'hDEADBEEF);
        chk("rd5_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        step();
        chk("rd5_b_rvalid_drop", {31'd0, b_rvalid}, 32'd0);
        chk("rd5_b_rdata_hold", b_rdata, 32'hDEADBEEF);

        // Same-bank conflict held for three cycles: grants go a, b, a.
        a_valid = 1; a_wen = 0; a_addr = 10'd4;
        b_valid = 1; b_wen = 0; b_addr = 10'd8;
        #1;
        chk("cf1_a_ready", {31'd0, a_ready}, 32'd1);
        chk("cf1_b_ready", {31'd0, b_ready}, 32'd0);
        step();
        chk("cf2_a_ready", {31'd0, a_ready}, 32'd0);
        chk("cf2_b_ready", {31'd0, b_ready}, 32'd1);
        step();
        chk("cf3_a_ready", {31'd0, a_ready}, 32'd1);
        chk("cf3_b_ready", {31'd0, b_ready}, 32'd0);
        step();
        idle();
        step();

        // Different banks: a streams reads of address 1 and b streams reads
        // of address 2 for 100 cycles.
        a_valid = 1; a_wen = 1; a_addr = 10'd1; a_wdata = 32'hA1A10001;
        b_valid = 1; b_wen = 1; b_addr = 10'd2; b_wdata = 32'hB2B20002;
        #1;
        chk("st_wr_a_ready", {31'd0, a_ready}, 32'd1);
        chk("st_wr_b_ready", {31'd0, b_ready}, 32'd1);
        step();
        idle();
        a_cnt = 0;
        b_cnt = 0;
        for (int i = 0; i <= 102; i++) begin
            if (a_rvalid === 1'b1) begin
                a_cnt++;
                chk("st_a_rdata", a_rdata, 32'hA1A10001);
            end
            if (b_rvalid === 1'b1) begin
                b_cnt++;
                chk("st_b_rdata", b_rdata, 32'hB2B20002);
            end
            if (i < 100) begin
                a_valid = 1; a_wen = 0; a_addr = 10'd1;
                b_valid = 1; b_wen = 0; b_addr = 10'd2;
                #1;
                chk("st_a_ready", {31'd0, a_ready}, 32'd1);
                chk("st_b_ready", {31'd0, b_ready}, 32'd1);
            end else begin
                idle();
            end
            step();
        end
        chk("st_a_count", a_cnt, 100);
        chk("st_b_count", b_cnt, 100);

        // A read accepted just before reset must never be returned.
        a_valid = 1; a_wen = 0; a_addr = 10'd5;
        #1;
        chk("rr_a_ready", {31'd0, a_ready}, 32'd1);
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("rr_rvalid_in_rst", {31'd0, a_rvalid}, 32'd0);
        chk("rr_ready_in_rst", {31'd0, a_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rr_rvalid_after", {31'd0, a_rvalid}, 32'd0);
        chk("rr_a_rdata_zero", a_rdata, 32'd0);
        chk("rr_b_rdata_zero", b_rdata, 32'd0);
        step();
        chk("rr_rvalid_late", {31'd0, a_rvalid}, 32'd0);
        // Before reset, priority had been left with b; it must be back at a.
        a_valid = 1; a_wen = 0; a_addr = 10'd0;
        b_valid = 1; b_wen = 0; b_addr = 10'd4;
        #1;
        chk("rr_prio_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rr_prio_b_ready", {31'd0, b_ready}, 32'd0);
        step();
        idle();
        step();

        // Single bank: a writes 0x11 at address 3 while b reads address 3.
        sa_valid = 1; sa_wen = 1; sa_addr = 4'd3; sa_wdata = 32'h11;
        sb_valid = 1; sb_wen = 0; sb_addr = 4'd3;
        #1;
        chk("one_a_ready", {31'd0, sa_ready}, 32'd1);
        chk("one_b_ready", {31'd0, sb_ready}, 32'd0);
        step();
        sa_valid = 0; sa_wen = 0;
        #1;
        chk("one_b_ready2", {31'd0, sb_ready}, 32'd1);
        step();
        idle();
        lat = 1;
        while (sb_rvalid !== 1'b1 && lat < 6) begin
            step();
            lat++;
        end
        chk("one_latency", lat, L);
        chk("one_b_rdata", sb_rdata, 32'h11);
        step();
        // Different addresses still conflict with one bank; priority is now b.
        sa_valid = 1; sa_wen = 0; sa_addr = 4'd0;
        sb_valid = 1; sb_wen = 0; sb_addr = 4'd1;
        #1;
        chk("one_cf_a_ready", {31'd0, sa_ready}, 32'd0);
        chk("one_cf_b_ready", {31'd0, sb_ready}, 32'd1);
        step();
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
